// File: rtl/multicycle_core.sv
// Multicycle RV32I core: one shared req/ready memory port, one ALU, one register file; MC_TRAP_EN traps unknown opcodes.
// 3-5 states per instruction plus wait cycles; mem_req/we/addr/wdata are held until mem_ready completes the access.
module multicycle_core #(
    parameter int                    WIDTH_DATA = 32,
    parameter int                    WIDTH_ADDR = 32,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    input  logic [WIDTH_DATA-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  retire,
    output logic [WIDTH_ADDR-1:0] pc_out,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        st_idle, st_fetch, st_decode, st_memadr, st_memread, st_memwb, st_memwrite,
        st_execr, st_execi, st_aluwb, st_beq, st_jal
`ifdef MC_TRAP_EN
        , st_trap
`endif
    } state_t;

    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_reg    = 7'b0110011;
    localparam logic [6:0] op_imm    = 7'b0010011;
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [6:0] op_jal    = 7'b1101111;

    state_t                state, state_nx;
    logic [WIDTH_ADDR-1:0] pc, old_pc;
    logic [31:0]           ir;
    logic [WIDTH_DATA-1:0] mdr, a, b, alu_out;
    logic [WIDTH_DATA-1:0] rf [0:31];

    logic [6:0]            opcode;
    logic [4:0]            rs1, rs2, rd;
    logic [2:0]            funct3;
    logic signed [31:0]    imm_i, imm_s, imm_b, imm_j;
    logic [WIDTH_DATA-1:0] rd1, rd2, alu_b, alu_res;
    logic                  alu_lt, use_alu_addr, rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];

    // Second ALU operand: register B for R-type, store offset for sw address, I-immediate otherwise.
    assign alu_b  = (state == st_execr) ? b :
                    (opcode == op_store) ? WIDTH_DATA'(imm_s) : WIDTH_DATA'(imm_i);
    assign alu_lt = $signed(a) < $signed(alu_b);

    always_comb begin
        alu_res = a + alu_b;
        if (state == st_execr || state == st_execi) begin
            case (funct3)
                3'b000:  alu_res = (state == st_execr && ir[30]) ? a - alu_b : a + alu_b;
                3'b010:  alu_res = {{(WIDTH_DATA-1){1'b0}}, alu_lt};
                3'b110:  alu_res = a | alu_b;
                3'b111:  alu_res = a & alu_b;
                default: alu_res = a + alu_b;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= st_idle;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        use_alu_addr = 1'b0;
        retire       = 1'b0;
        rf_we        = 1'b0;
        case (state)
            st_idle:   state_nx = st_fetch;
            st_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) state_nx = st_decode;
            end
            st_decode: begin
                case (opcode)
                    op_load, op_store: state_nx = st_memadr;
                    op_reg:            state_nx = st_execr;
                    op_imm:            state_nx = st_execi;
                    op_branch:         state_nx = st_beq;
                    op_jal:            state_nx = st_jal;
`ifdef MC_TRAP_EN
                    default:           state_nx = st_trap;
`else
                    default:           state_nx = st_fetch;
`endif
                endcase
            end
            st_memadr: state_nx = (opcode == op_store) ? st_memwrite : st_memread;
            st_memread: begin
                mem_req      = 1'b1;
                use_alu_addr = 1'b1;
                if (mem_ready) state_nx = st_memwb;
            end
            st_memwrite: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                use_alu_addr = 1'b1;
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = st_fetch;
                end
            end
            st_memwb, st_aluwb: begin
                rf_we    = (rd != 5'd0);
                retire   = 1'b1;
                state_nx = st_fetch;
            end
            st_execr, st_execi, st_jal: state_nx = st_aluwb;
            st_beq: begin
                retire   = 1'b1;
                state_nx = st_fetch;
            end
            default: state_nx = state;
        endcase
    end

    assign mem_addr  = use_alu_addr ? WIDTH_ADDR'(alu_out) : pc;
    assign mem_wdata = b;
    assign pc_out    = old_pc;

`ifdef MC_TRAP_EN
    assign illegal = (state == st_trap);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            old_pc  <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            case (state)
                st_fetch: if (mem_ready) begin
                    ir     <= mem_rdata[31:0];
                    old_pc <= pc;
                    pc     <= pc + WIDTH_ADDR'(4);
                end
                st_decode: begin
                    a <= rd1;
                    b <= rd2;
                end
                st_memadr, st_execr, st_execi: alu_out <= alu_res;
                st_memread: if (mem_ready) mdr <= mem_rdata;
                st_beq: if (a == b) pc <= old_pc + WIDTH_ADDR'(imm_b);
                st_jal: begin
                    pc      <= old_pc + WIDTH_ADDR'(imm_j);
                    alu_out <= WIDTH_DATA'(old_pc + WIDTH_ADDR'(4));
                end
                default: ;
            endcase
        end
    end

    // Register file is deliberately left unreset; x0 is handled on the read side.
    always_ff @(posedge clk) begin
        if (rf_we) rf[rd] <= (state == st_memwb) ? mdr : alu_out;
    end

endmodule
